// File: rtl/bscan_pkg.sv
// Shared types and constants for the right-bottom IO column boundary-scan sequencer.
package bscan_pkg;

  localparam int unsigned IO_CELLS_PER_PAD  = 3;
  localparam int unsigned NUM_PADS          = 13;
  localparam int unsigned CHAIN_LEN_DEFAULT = NUM_PADS * IO_CELLS_PER_PAD;

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StShift,
    StUpdate,
    StDone
  } bscan_state_t;

endpackage

// File: rtl/bscan_chain_seq_if.sv
// Request/response and serial chain signals between the JTAG logic, the sequencer and the IO column.
interface bscan_chain_seq_if #(
  parameter int unsigned CHAIN_LEN = bscan_pkg::CHAIN_LEN_DEFAULT
);

  logic                 start;
  logic                 extest;
  logic [CHAIN_LEN-1:0] load_data;
  logic                 sdo;
  logic                 busy;
  logic                 done;
  logic [CHAIN_LEN-1:0] capture_data;
  logic                 sdi;
  logic                 shift;
  logic                 update;
  logic                 hold;
  logic                 bs_en;
  logic                 hiz_b;

  modport slave (
    input  start, extest, load_data, sdo,
    output busy, done, capture_data, sdi, shift, update, hold, bs_en, hiz_b
  );

  modport master (
    output start, extest, load_data, sdo,
    input  busy, done, capture_data, sdi, shift, update, hold, bs_en, hiz_b
  );

endinterface

// File: rtl/bscan_shreg.sv
// Parallel-load shift register feeding sdi, plus the serial-in shadow that collects sdo
// one bit per shift cycle at the position given by bit_idx.
module bscan_shreg #(
  parameter int unsigned WIDTH = 39,
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic [IDX_W-1:0] bit_idx,
  input  logic             ser_in,
  output logic             ser_out,
  output logic [WIDTH-1:0] shadow
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] shadow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q     <= '0;
      shadow_q <= '0;
    end else if (load) begin
      sr_q <= load_data;
    end else if (shift_en) begin
      sr_q               <= sr_q >> 1;
      shadow_q[bit_idx]  <= ser_in;
    end
  end

  assign ser_out = sr_q[0];
  assign shadow  = shadow_q;

endmodule

// File: rtl/bscan_chain_seq.sv
// Boundary-scan pass sequencer: capture pads, shift a new vector in while reading the old one
// out, then strobe update. FSM and bit counter live here; the data registers in bscan_shreg.
module bscan_chain_seq
  import bscan_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEFAULT,
  parameter int unsigned CNT_W     = 6
) (
  input logic              tclk,
  input logic              r,
  bscan_chain_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(CHAIN_LEN - 1);

  bscan_state_t         state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 extest_q;
  logic [CHAIN_LEN-1:0] cap_q;
  logic [CHAIN_LEN-1:0] shadow;
  logic                 sr_out;
  logic                 accept;
  logic                 in_shift;

  assign accept   = (state_q == StIdle) && bus.start;
  assign in_shift = (state_q == StShift);

  always_ff @(posedge tclk or posedge r) begin
    if (r) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (bus.start) state_d = StCapture;
      StCapture: state_d = StShift;
      StShift:   if (cnt_q == LastIdx) state_d = StUpdate;
      StUpdate:  state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge tclk or posedge r) begin
    if (r) begin
      cnt_q    <= '0;
      extest_q <= 1'b0;
      cap_q    <= '0;
    end else begin
      if (accept) extest_q <= bus.extest;
      if (state_q == StCapture) begin
        cnt_q <= '0;
      end else if (in_shift) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state_q == StUpdate) cap_q <= shadow;
    end
  end

  bscan_shreg #(
    .WIDTH (CHAIN_LEN),
    .IDX_W (CNT_W)
  ) u_shreg (
    .clk       (tclk),
    .rst       (r),
    .load      (accept),
    .load_data (bus.load_data),
    .shift_en  (in_shift),
    .bit_idx   (cnt_q),
    .ser_in    (bus.sdo),
    .ser_out   (sr_out),
    .shadow    (shadow)
  );

  // Pads are tristated for the whole active part of a sample-only pass; in IDLE bs_en keeps
  // the last extest so an EXTEST pass leaves the pads under scan control.
  always_comb begin
    bus.busy   = 1'b1;
    bus.done   = 1'b0;
    bus.shift  = 1'b0;
    bus.update = 1'b0;
    bus.hold   = 1'b1;
    bus.bs_en  = 1'b1;
    bus.hiz_b  = extest_q;
    case (state_q)
      StIdle: begin
        bus.busy  = 1'b0;
        bus.bs_en = extest_q;
        bus.hiz_b = 1'b1;
      end
      StShift:  bus.shift = 1'b1;
      StUpdate: begin
        bus.update = 1'b1;
        bus.hold   = 1'b0;
      end
      StDone: begin
        bus.done  = 1'b1;
        bus.hiz_b = 1'b1;
      end
      default: ;
    endcase
    bus.sdi = in_shift & sr_out;
  end

  assign bus.capture_data = cap_q;

endmodule

// File: tb/tb_bscan_chain_seq.sv
// Randomised scoreboard bench for bscan_chain_seq with a simple serial chain model on sdi/sdo.
module tb_bscan_chain_seq;

  localparam int N        = 39;
  localparam int PASS_CYC = N + 3;

  typedef struct {
    logic [N-1:0] cap;
    logic [N-1:0] sdi;
  } exp_t;

  logic tclk = 1'b0;
  logic r    = 1'b1;
  int   total = 0;
  int   bad   = 0;

  bscan_chain_seq_if #(.CHAIN_LEN(N)) bus ();

  bscan_chain_seq #(
    .CHAIN_LEN (N),
    .CNT_W     (6)
  ) dut (
    .tclk (tclk),
    .r    (r),
    .bus  (bus)
  );

  always #5 tclk = ~tclk;

  // IO column chain: N cells, sdo is the oldest bit; optionally overridden by a constant.
  logic [N-1:0] chain     = '0;
  logic         force_en  = 1'b0;
  logic         force_val = 1'b0;
  always @(posedge tclk) if (bus.shift) chain <= {bus.sdi, chain[N-1:1]};
  assign bus.sdo = force_en ? force_val : chain[0];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: pass phase by cycle number since acceptance (0 = idle).
  exp_t         sb[$];
  int           m_cyc     = 0;
  logic         m_ext     = 1'b0;
  logic [N-1:0] m_load    = '0;
  logic [N-1:0] last_load = '0;

  always @(posedge tclk or posedge r) begin
    if (r) begin
      m_cyc <= 0;
      m_ext <= 1'b0;
      sb.delete();
    end else if (m_cyc == 0) begin
      if (bus.start) begin
        m_cyc  <= 1;
        m_ext  <= bus.extest;
        m_load <= bus.load_data;
        sb.push_back('{cap: (force_en ? {N{force_val}} : last_load), sdi: bus.load_data});
      end
    end else begin
      if (m_cyc == N + 1) last_load <= m_load;
      m_cyc <= (m_cyc == PASS_CYC) ? 0 : m_cyc + 1;
    end
  end

  // {busy, done, shift, update, hold, bs_en, hiz_b}
  function automatic logic [6:0] exp_ctrl(input int c, input logic ext);
    if (c == 0)             return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ext,  1'b1};
    else if (c == 1)        return {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ext};
    else if (c <= N + 1)    return {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, ext};
    else if (c == N + 2)    return {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ext};
    else                    return {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  endfunction

  int           k       = 0;
  logic [N-1:0] sdi_acc = '0;
  exp_t         e;

  always @(negedge tclk) begin
    check("ctrl", 64'({bus.busy, bus.done, bus.shift, bus.update, bus.hold, bus.bs_en,
                       bus.hiz_b}), 64'(exp_ctrl(m_cyc, m_ext)));
    if (r) begin
      k = 0;
    end else begin
      if (bus.shift && k < N) begin
        sdi_acc[k] = bus.sdi;
        k++;
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL done_unexpected: got done=1 expected no pending pass at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("capture_data", 64'(bus.capture_data), 64'(e.cap));
          check("sdi_stream", 64'(sdi_acc), 64'(e.sdi));
        end
        k = 0;
      end
    end
  end

  task automatic wait_for(input int c);
    int n = 0;
    while (m_cyc != c) begin
      @(posedge tclk);
      #1;
      n++;
      if (n > 200) begin
        total++;
        bad++;
        $display("FAIL wait_timeout: got cycle %0d expected %0d", m_cyc, c);
        break;
      end
    end
  endtask

  task automatic run_pass(input logic ext, input logic [N-1:0] data, input bit keep_start);
    int n = 0;
    bus.extest    = ext;
    bus.load_data = data;
    bus.start     = 1'b1;
    do begin
      @(posedge tclk);
      #1;
      n++;
    end while (m_cyc != 1 && n <= 200);
    if (m_cyc != 1) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got cycle %0d expected 1", m_cyc);
    end
    if (!keep_start) bus.start = 1'b0;
  endtask

  function automatic logic [N-1:0] rnd_vec();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[N-1:0];
  endfunction

  initial begin
    bus.start     = 1'b0;
    bus.extest    = 1'b0;
    bus.load_data = '0;
    repeat (3) @(posedge tclk);
    #1;
    check("rst_capture_data", 64'(bus.capture_data), 64'd0);
    check("rst_sdi", 64'(bus.sdi), 64'd0);
    check("rst_hold", 64'(bus.hold), 64'd1);
    check("rst_hiz_b", 64'(bus.hiz_b), 64'd1);
    r = 1'b0;
    repeat (2) @(posedge tclk);
    #1;

    // Sample-only pass with sdo tied high.
    force_en  = 1'b1;
    force_val = 1'b1;
    run_pass(1'b0, 39'h55_5555_5555, 1'b0);
    wait_for(0);
    check("sample_capture", 64'(bus.capture_data), 64'h7F_FFFF_FFFF);

    // Loopback through the chain model.
    force_en = 1'b0;
    run_pass(1'b0, 39'h12_3456_789A, 1'b0);
    wait_for(0);
    run_pass(1'b0, '0, 1'b0);
    wait_for(0);
    check("loopback_capture", 64'(bus.capture_data), 64'h12_3456_789A);

    // EXTEST pass; pads must stay under scan control afterwards.
    run_pass(1'b1, rnd_vec(), 1'b0);
    wait_for(0);
    repeat (2) @(posedge tclk);
    #1;
    check("extest_bs_en_idle", 64'(bus.bs_en), 64'd1);

    // start pulsed mid-SHIFT with different data must be ignored.
    run_pass(1'b0, rnd_vec(), 1'b0);
    wait_for(12);
    bus.start     = 1'b1;
    bus.extest    = 1'b1;
    bus.load_data = ~bus.load_data;
    @(posedge tclk);
    #1;
    bus.start = 1'b0;
    wait_for(0);

    // Back-to-back passes with start held through DONE.
    run_pass(1'b1, rnd_vec(), 1'b1);
    run_pass(1'b0, rnd_vec(), 1'b0);
    wait_for(0);

    for (int i = 0; i < 6; i++) begin
      force_en  = 1'($urandom_range(0, 1));
      force_val = 1'($urandom_range(0, 1));
      run_pass(1'($urandom_range(0, 1)), rnd_vec(), 1'b0);
      wait_for(0);
      repeat ($urandom_range(0, 3)) @(posedge tclk);
      #1;
    end

    // Mid-pass reset: previous capture is zero, aborted pass reads ones.
    force_en  = 1'b1;
    force_val = 1'b0;
    run_pass(1'b0, rnd_vec(), 1'b0);
    wait_for(0);
    force_val = 1'b1;
    run_pass(1'b0, rnd_vec(), 1'b0);
    wait_for(22);
    r = 1'b1;
    #1;
    check("reset_shift", 64'(bus.shift), 64'd0);
    check("reset_update", 64'(bus.update), 64'd0);
    repeat (2) @(posedge tclk);
    #1;
    r = 1'b0;
    check("reset_capture_kept", 64'(bus.capture_data), 64'd0);
    run_pass(1'b0, rnd_vec(), 1'b0);
    wait_for(0);
    check("after_reset_capture", 64'(bus.capture_data), 64'h7F_FFFF_FFFF);

    repeat (3) @(posedge tclk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
